// File: rtl/lock_pkg.sv
// Shared definitions for the two-button sequential lock and its code sender.
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS  = 3'd1,
        GAP    = 3'd2,
        WAIT   = 3'd3,
        REPORT = 3'd4
    } state_t;

    localparam int LOCK_CODE_LEN = 5;

    // Presses b0, b1, b0, b1, b1: the sequence the lock accepts.
    localparam logic [LOCK_CODE_LEN-1:0] LOCK_CODE_DEFAULT = 5'b01011;

endpackage

// File: rtl/lock_code_sender.sv
// Drives a captured code onto the lock's b0/b1 buttons as single-cycle pulses,
// then watches unlock for a bounded window and reports done or fail.
module lock_code_sender
    import lock_pkg::*;
#(
    parameter int CODE_LEN   = LOCK_CODE_LEN,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [CODE_LEN-1:0] code,
    input  logic                unlock,
    output logic                b0,
    output logic                b1,
    output logic                busy,
    output logic                done,
    output logic                fail
);

    localparam int IDX_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CODE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(TIMEOUT - 1);

    state_t              r_state;
    logic [CODE_LEN-1:0] r_code;
    logic [IDX_W-1:0]    r_idx;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_b0;
    logic                r_b1;
    logic                r_done;
    logic                r_fail;

    state_t              w_state_next;
    logic [CODE_LEN-1:0] w_code_next;
    logic [CODE_LEN-1:0] w_code_shift;
    logic [IDX_W-1:0]    w_idx_next;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_b0_next;
    logic                w_b1_next;
    logic                w_done_next;
    logic                w_fail_next;

    // The code register shifts left so the bit to send is always the MSB.
    assign w_code_shift = r_code << 1;

    assign b0   = r_b0;
    assign b1   = r_b1;
    assign done = r_done;
    assign fail = r_fail;
    assign busy = (r_state != IDLE);

    // Next-state and next-output decode; button pulses are computed one cycle ahead and registered.
    always_comb begin
        w_state_next = r_state;
        w_code_next  = r_code;
        w_idx_next   = r_idx;
        w_cnt_next   = r_cnt;
        w_b0_next    = 1'b0;
        w_b1_next    = 1'b0;
        w_done_next  = 1'b0;
        w_fail_next  = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_code_next  = code;
                    w_idx_next   = '0;
                    w_state_next = PRESS;
                    w_b1_next    = code[CODE_LEN-1];
                    w_b0_next    = ~code[CODE_LEN-1];
                end
            end
            PRESS: begin
                if (r_idx == LAST_IDX) begin
                    w_state_next = WAIT;
                    w_cnt_next   = WAIT_LOAD;
                end else begin
                    w_idx_next  = r_idx + IDX_W'(1);
                    w_code_next = w_code_shift;
                    if (GAP_CYCLES == 0) begin
                        w_state_next = PRESS;
                        w_b1_next    = w_code_shift[CODE_LEN-1];
                        w_b0_next    = ~w_code_shift[CODE_LEN-1];
                    end else begin
                        w_state_next = GAP;
                        w_cnt_next   = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (r_cnt == '0) begin
                    w_state_next = PRESS;
                    w_b1_next    = r_code[CODE_LEN-1];
                    w_b0_next    = ~r_code[CODE_LEN-1];
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            WAIT: begin
                if (unlock) begin
                    w_state_next = REPORT;
                    w_done_next  = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_next = REPORT;
                    w_fail_next  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            REPORT: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (abort) begin
            w_state_next = IDLE;
            w_b0_next    = 1'b0;
            w_b1_next    = 1'b0;
            w_done_next  = 1'b0;
            w_fail_next  = 1'b0;
        end
    end

    // State, datapath and registered outputs; reset clears the button lines immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_code  <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_b0    <= 1'b0;
            r_b1    <= 1'b0;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_code  <= w_code_next;
            r_idx   <= w_idx_next;
            r_cnt   <= w_cnt_next;
            r_b0    <= w_b0_next;
            r_b1    <= w_b1_next;
            r_done  <= w_done_next;
            r_fail  <= w_fail_next;
        end
    end

endmodule
